// File: rtl/lcd_ctrl_pkg.sv
// Shared constants, FSM state type and index-width helper for the LCD screen controller.
package lcd_ctrl_pkg;

  localparam int         ROWS_C       = 2;
  localparam int         MAX_COLS_C   = 40;
  localparam logic [7:0] CHAR_SPACE_C = 8'h20;

  typedef enum logic {
    SCAN = 1'b0,
    REQ  = 1'b1
  } lcd_state_e;

  function automatic int idx_width(input int cells);
    return (cells <= 1) ? 1 : $clog2(cells);
  endfunction

endpackage

// File: rtl/lcd_frame_buf.sv
// Character image with per-cell dirty bits; one write port, one combinational scan read.
module lcd_frame_buf
  import lcd_ctrl_pkg::*;
#(
  parameter int COLS = 16,
  localparam int CELLS = ROWS_C * COLS,
  localparam int IW = idx_width(CELLS)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          wr_en,
  input  logic [IW-1:0] wr_idx,
  input  logic [7:0]    wr_char,
  input  logic          clear,
  input  logic [IW-1:0] rd_idx,
  input  logic          dirty_clr,
  output logic [7:0]    rd_char,
  output logic          rd_dirty,
  output logic          any_dirty_nxt
);

  logic [7:0]       mem_q   [CELLS];
  logic [7:0]       mem_d   [CELLS];
  logic [CELLS-1:0] dirty_q;
  logic [CELLS-1:0] dirty_d;

  assign rd_char       = mem_q[rd_idx];
  assign rd_dirty      = dirty_q[rd_idx];
  assign any_dirty_nxt = |dirty_d;

  // Client write is applied after the scan's clear-dirty so a same-cycle write stays pending.
  always_comb begin
    mem_d   = mem_q;
    dirty_d = dirty_q;
    if (clear) begin
      for (int i = 0; i < CELLS; i++) mem_d[i] = CHAR_SPACE_C;
      dirty_d = '1;
    end else begin
      if (dirty_clr) dirty_d[rd_idx] = 1'b0;
      if (wr_en) begin
        mem_d[wr_idx]   = wr_char;
        dirty_d[wr_idx] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < CELLS; i++) mem_q[i] <= CHAR_SPACE_C;
      dirty_q <= '1;
    end else begin
      for (int i = 0; i < CELLS; i++) mem_q[i] <= mem_d[i];
      dirty_q <= dirty_d;
    end
  end

endmodule

// File: rtl/lcd_screen_ctrl.sv
// Scans the frame buffer round-robin and pushes each dirty cell to the LCD driver over rq/ack.
//
// state | meaning
// SCAN  | test the cell at the scan pointer, one per cycle; a dirty cell launches a request
// REQ   | lcd_rq and lcd_* fields held until the driver acks
module lcd_screen_ctrl
  import lcd_ctrl_pkg::*;
#(
  parameter int COLS = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       wr_en,
  input  logic       wr_row,
  input  logic [5:0] wr_col,
  input  logic [7:0] wr_char,
  input  logic       clear,
  output logic       busy,
  output logic       lcd_rq,
  input  logic       lcd_ack,
  output logic       lcd_row,
  output logic [5:0] lcd_column,
  output logic [7:0] lcd_character
);

  localparam int CELLS = ROWS_C * COLS;
  localparam int IW    = idx_width(CELLS);

  lcd_state_e    state_q, state_d;
  logic          ptr_row_q, ptr_row_d;
  logic [5:0]    ptr_col_q, ptr_col_d;
  logic          rq_q, rq_d;
  logic          row_q, row_d;
  logic [5:0]    col_q, col_d;
  logic [7:0]    char_q, char_d;
  logic          busy_q, busy_d;

  logic          wr_valid;
  logic [IW-1:0] wr_idx;
  logic [IW-1:0] rd_idx;
  logic [7:0]    rd_char;
  logic          rd_dirty;
  logic          dirty_clr;
  logic          any_dirty_nxt;

  assign wr_valid = wr_en && (int'(wr_col) < COLS);
  assign wr_idx   = IW'(int'(wr_row) * COLS + int'(wr_col));
  assign rd_idx   = IW'(int'(ptr_row_q) * COLS + int'(ptr_col_q));

  lcd_frame_buf #(.COLS(COLS)) u_frame_buf (
    .clk           (clk),
    .rst_n         (rst_n),
    .wr_en         (wr_valid),
    .wr_idx        (wr_idx),
    .wr_char       (wr_char),
    .clear         (clear),
    .rd_idx        (rd_idx),
    .dirty_clr     (dirty_clr),
    .rd_char       (rd_char),
    .rd_dirty      (rd_dirty),
    .any_dirty_nxt (any_dirty_nxt)
  );

  always_comb begin
    state_d   = state_q;
    ptr_row_d = ptr_row_q;
    ptr_col_d = ptr_col_q;
    rq_d      = rq_q;
    row_d     = row_q;
    col_d     = col_q;
    char_d    = char_q;
    dirty_clr = 1'b0;
    unique case (state_q)
      SCAN: begin
        if (rd_dirty) begin
          row_d     = ptr_row_q;
          col_d     = ptr_col_q;
          char_d    = rd_char;
          dirty_clr = 1'b1;
          rq_d      = 1'b1;
          state_d   = REQ;
        end
      end
      REQ: begin
        if (lcd_ack) begin
          rq_d    = 1'b0;
          state_d = SCAN;
        end
      end
      default: state_d = SCAN;
    endcase
    // Pointer moves past a clean cell, or past the cell whose transfer just completed.
    if ((state_q == SCAN && !rd_dirty) || (state_q == REQ && lcd_ack)) begin
      if (ptr_col_q == 6'(COLS - 1)) begin
        ptr_col_d = '0;
        ptr_row_d = ~ptr_row_q;
      end else begin
        ptr_col_d = ptr_col_q + 6'd1;
      end
    end
    busy_d = any_dirty_nxt || (state_d == REQ);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= SCAN;
      ptr_row_q <= 1'b0;
      ptr_col_q <= '0;
      rq_q      <= 1'b0;
      row_q     <= 1'b0;
      col_q     <= '0;
      char_q    <= CHAR_SPACE_C;
      busy_q    <= 1'b1;
    end else begin
      state_q   <= state_d;
      ptr_row_q <= ptr_row_d;
      ptr_col_q <= ptr_col_d;
      rq_q      <= rq_d;
      row_q     <= row_d;
      col_q     <= col_d;
      char_q    <= char_d;
      busy_q    <= busy_d;
    end
  end

  assign busy          = busy_q;
  assign lcd_rq        = rq_q;
  assign lcd_row       = row_q;
  assign lcd_column    = col_q;
  assign lcd_character = char_q;

endmodule
